// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Purpose  : Pops a registered-read FIFO into a 2-entry buffer and presents
//            the words as a valid/ready stream, with priming, flush and a
//            saturating underrun counter. Optional FIFO_READER_HOLD_LAST_EN
//            repeats the last popped word while the buffer is empty in RUN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_reader #(
    parameter int W     = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    input  logic [W-1:0]     fifo_data,
    output logic             fifo_re,
    input  logic             flush,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_repeat,
    output logic [CNT_W-1:0] underrun_cnt
);

    localparam logic [0:0]       c_ST_IDLE = 1'b0;
    localparam logic [0:0]       c_ST_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [1:0]       r_occ;
    logic             r_inflight;
    logic [W-1:0]     r_head;
    logic [W-1:0]     r_tail;
    logic [W-1:0]     w_head_next;
    logic [W-1:0]     w_tail_next;
    logic [CNT_W-1:0] r_underrun;

    logic             w_run;
    logic             w_has_data;
    logic             w_pop;
    logic             w_underrun;
    logic [1:0]       w_level;
    logic [1:0]       w_base;

    assign w_run      = (r_state == c_ST_RUN);
    assign w_has_data = (r_occ != 2'd0);
    assign w_pop      = w_run & w_has_data & out_ready;
    assign w_underrun = w_run & ~w_has_data & out_ready;

    // Buffer level after this cycle's capture and pop; never exceeds 2
    // because a read is only issued while this is below 2.
    assign w_level = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_base  = r_occ - {1'b0, w_pop};

    assign fifo_re = ~reset & ~fifo_empty & ~flush & (w_level < 2'd2);

    always_comb begin
        w_head_next = w_pop ? r_tail : r_head;
        w_tail_next = r_tail;
        if (r_inflight) begin
            if (w_base == 2'd0) begin
                w_head_next = fifo_data;
            end else begin
                w_tail_next = fifo_data;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if ((r_state == c_ST_IDLE) && (w_level == 2'd2)) begin
            w_state_next = c_ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state    <= c_ST_IDLE;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_occ      <= w_level;
            r_inflight <= fifo_re;
            r_head     <= w_head_next;
            r_tail     <= w_tail_next;
        end
    end

    // Flush leaves the counter intact but suppresses counting in its cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun <= '0;
        end else if (!flush && w_underrun && (r_underrun != '1)) begin
            r_underrun <= r_underrun + c_CNT_ONE;
        end
    end

    assign underrun_cnt = r_underrun;

`ifdef FIFO_READER_HOLD_LAST_EN
    logic [W-1:0] r_last;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_last <= '0;
        end else if (w_pop) begin
            r_last <= r_head;
        end
    end

    assign out_valid  = w_run;
    assign out_repeat = w_run & ~w_has_data;
    assign out_data   = (w_run && !w_has_data) ? r_last : r_head;
`else
    assign out_valid  = w_run & w_has_data;
    assign out_repeat = 1'b0;
    assign out_data   = r_head;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_reader
// Purpose  : Directed bench for fifo_stream_reader with a behavioural
//            registered-read FIFO in front of it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_reader;

    localparam int W     = 6;
    localparam int CNT_W = 4;

`ifdef FIFO_READER_HOLD_LAST_EN
    localparam logic c_HOLD = 1'b1;
`else
    localparam logic c_HOLD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             fifo_empty;
    logic [W-1:0]     fifo_data;
    logic             fifo_re;
    logic             flush;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_repeat;
    logic [CNT_W-1:0] underrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_re      (fifo_re),
        .flush        (flush),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_repeat   (out_repeat),
        .underrun_cnt (underrun_cnt)
    );

    // Behavioural FIFO: data appears on fifo_data the cycle after a read.
    logic [W-1:0] mem [0:255];
    int           wr_ptr = 0;
    int           rd_ptr = 0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (reset) begin
            rd_ptr    <= wr_ptr;
            fifo_data <= '0;
        end else if (fifo_re && !fifo_empty) begin
            fifo_data <= mem[rd_ptr[7:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
    endtask

    // Stream monitor used by the backpressure scenario.
    logic         mon_en = 1'b0;
    int           n_rd   = 0;
    int           n_pop  = 0;
    logic [W-1:0] got [$];

    always @(negedge clk) begin
        if (mon_en) begin
            check("re_while_empty", 32'(fifo_re & fifo_empty), 32'd0);
            check("occ_le_2", 32'((n_rd - n_pop) <= 2), 32'd1);
            if (fifo_re && !fifo_empty) n_rd++;
            if (out_valid && out_ready && !out_repeat) begin
                got.push_back(out_data);
                n_pop++;
            end
        end
    end

    initial begin
        // ---------------- reset state and priming ----------------
        do_reset();
        push(6'h3F);
        #1;
        check("rst_fifo_re",   32'(fifo_re), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data), 32'd0);
        check("rst_out_repeat", 32'(out_repeat), 32'd0);
        check("rst_underrun",  32'(underrun_cnt), 32'd0);

        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) push(W'(i));
        #1;
        check("prime_t0_re", 32'(fifo_re), 32'd1);
        check("prime_t0_valid", 32'(out_valid), 32'd0);
        step(); #1;
        check("prime_t1_re", 32'(fifo_re), 32'd1);
        check("prime_t1_valid", 32'(out_valid), 32'd0);
        step(); #1;
        check("prime_t2_re", 32'(fifo_re), 32'd0);
        check("prime_t2_valid", 32'(out_valid), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step(); #1;
            check("prime_valid", 32'(out_valid), 32'd1);
            check("prime_data", 32'(out_data), 32'(i));
        end
        check("prime_no_underrun", 32'(underrun_cnt), 32'd0);
        step(); #1;
        check("prime_empty_valid", 32'(out_valid), 32'(c_HOLD));
        check("prime_empty_repeat", 32'(out_repeat), 32'(c_HOLD));
        step();
        out_ready = 1'b0;
        #1;
        check("prime_first_underrun", 32'(underrun_cnt), 32'd1);

        // ---------------- backpressure 1,0,0,1 ----------------
        do_reset();
        step();
        reset = 1'b0;
        for (int i = 16; i < 32; i++) push(W'(i));
        n_rd  = 0;
        n_pop = 0;
        got.delete();
        mon_en = 1'b1;
        for (int c = 0; c < 80; c++) begin
            out_ready = ((c % 4) == 0) || ((c % 4) == 3);
            step();
        end
        mon_en = 1'b0;
        check("bp_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("bp_word", 32'(got[i]), 32'(16 + i));
        end

        // ---------------- underrun and saturation ----------------
        do_reset();
        step();
        reset = 1'b0;
        push(6'h2A);
        push(6'h2B);
        step(); step(); step();
        out_ready = 1'b1;
        #1;
        check("ur_first_valid", 32'(out_valid), 32'd1);
        check("ur_first_data", 32'(out_data), 32'h2A);
        step(); #1;
        check("ur_second_data", 32'(out_data), 32'h2B);
        check("ur_second_repeat", 32'(out_repeat), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step(); #1;
            check("ur_gap_valid", 32'(out_valid), 32'(c_HOLD));
            check("ur_gap_repeat", 32'(out_repeat), 32'(c_HOLD));
`ifdef FIFO_READER_HOLD_LAST_EN
            check("ur_hold_data", 32'(out_data), 32'h2B);
`endif
        end
        step();
        out_ready = 1'b0;
        #1;
        check("ur_count_8", 32'(underrun_cnt), 32'd8);
        step();
        out_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(); #1;
            if (k == 6) check("sat_14", 32'(underrun_cnt), 32'd14);
            if (k == 7) check("sat_15", 32'(underrun_cnt), 32'd15);
        end
        check("sat_hold", 32'(underrun_cnt), 32'hF);
        out_ready = 1'b0;

        // ---------------- flush mid-flight ----------------
        do_reset();
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 48; i < 64; i++) push(W'(i));
        step(); step(); step(); #1;
        check("fl_t3_data", 32'(out_data), 32'h30);
        step(); #1;
        check("fl_t4_data", 32'(out_data), 32'h31);
        step();
        out_ready = 1'b0;
        flush     = 1'b1;
        #1;
        check("fl_t5_data", 32'(out_data), 32'h32);
        check("fl_t5_re", 32'(fifo_re), 32'd0);
        step();
        flush     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("fl_after_valid", 32'(out_valid), 32'd0);
        check("fl_after_re", 32'(fifo_re), 32'd1);
        step(); #1;
        check("fl_t7_valid", 32'(out_valid), 32'd0);
        step(); #1;
        check("fl_t8_valid", 32'(out_valid), 32'd0);
        step(); #1;
        check("fl_reprime_valid", 32'(out_valid), 32'd1);
        check("fl_reprime_data", 32'(out_data), 32'h34);
        step(); #1;
        check("fl_next_data", 32'(out_data), 32'h35);
        step(); #1;
        check("fl_next2_data", 32'(out_data), 32'h36);
        check("fl_no_underrun", 32'(underrun_cnt), 32'd0);

        // ---------------- simultaneous capture and pop ----------------
        do_reset();
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60; i++) push(W'(i));
        step(); step();
        for (int k = 3; k <= 52; k++) begin
            step(); #1;
            check("ss_valid", 32'(out_valid), 32'd1);
            check("ss_data", 32'(out_data), 32'(k - 3));
            check("ss_re", 32'(fifo_re), 32'd1);
        end
        check("ss_no_underrun", 32'(underrun_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the synchronous FIFO that buffers data between the PPU domain and the display domain. It pops words from the FIFO, accounts for the FIFO's one-cycle registered read latency, and presents them as a valid/ready stream to the consumer, typically the VGA pixel pipe. It includes a 2-entry output buffer, a priming state machine, flush handling and a saturating underrun counter.

## Interface
- W, 6, data word width; must match the FIFO's data width
- CNT_W, 16, width of the underrun counter
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- fifo_empty  in  1  FIFO empty flag
- fifo_data  in  W  FIFO registered read data; updated the cycle after a read issued while not empty
- fifo_re  out  1  FIFO read enable
- flush  in  1  synchronous: discard buffered and in-flight data, return to IDLE
- out_data  out  W  head word of the output buffer
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer accepts out_data this cycle
- out_repeat  out  1  out_data is a repeated last word; constant 0 unless FIFO_READER_HOLD_LAST_EN is defined
- underrun_cnt  out  CNT_W  saturating count of underrun cycles

## Operation
- Reset: clk and reset are the only clock and reset. Reset is synchronous and active-high. On reset:
  - fifo_re=0, out_valid=0, out_data=0, out_repeat=0, underrun_cnt=0
  - Buffer occupancy occ=0, inflight=0, state=IDLE
- Internal state:
  - occ (0..2): number of words held in the 2-entry buffer
  - inflight (1 bit): set when a read was issued last cycle
  - pop = out_valid & out_ready
- Read issue: fifo_re = ~fifo_empty & ~flush & (occ + inflight − pop < 2).
- Capture: if inflight is set, fifo_data is written to the buffer tail at the end of the current cycle.
- Occupancy update: occ_next = occ + inflight − pop. Capture and pop in the same cycle are both honoured.
- States:
  - IDLE: out_valid=0, no underrun counting. Moves to RUN when occ reaches 2 (primed).
  - RUN: out_valid = (occ>0). Each cycle with out_ready=1 and occ=0 is an underrun, and underrun_cnt increments, saturating at all-ones.
  - Any state goes to IDLE on flush, with occ←0 and inflight←0. A word arriving from a read issued in the flush cycle −1 is dropped. underrun_cnt is not cleared by flush.
- out_data follows the buffer head and is stable while out_valid=1 and out_ready=0.
- The FIFO's own guard makes fifo_re while empty harmless, but this block never asserts it.

## Timing
- fifo_re is combinational from registered state, fifo_empty, flush and out_ready. The FIFO must meet this path.
- Read latency: fifo_re high at cycle t → fifo_data valid at t+1 → captured at the end of t+1 → visible at out_data at t+2, with out_valid=1 only if in RUN.
- Priming: from reset with the FIFO non-empty, reads issue at t0 and t1, occ=2 at the end of t2, and out_valid first goes high at t3.
- Steady state with out_ready=1 and the FIFO never empty: one pop per cycle, occ=1, inflight=1, fifo_re held high.
- Backpressure: with out_ready=0, at most 2 further reads complete after the stall begins. No word is ever lost or duplicated.
- Flush dominates all other events in the same cycle. Reset dominates flush.

## Configuration
- FIFO_READER_HOLD_LAST_EN defined:
  - In RUN with occ=0, out_valid stays 1 and out_data holds the last popped word, with out_repeat=1.
  - underrun_cnt still counts these cycles.
  - Before any pop since reset or flush, the repeated value is 0.
- Not defined: out_valid=0 whenever occ=0, and out_repeat is tied 0.

## Test plan
- Reset priming: FIFO preloaded with 0x01..0x04, out_ready=1 → out_valid rises 3 cycles after reset release, output sequence 0x01,0x02,0x03,0x04 on consecutive cycles, underrun_cnt=0 while data lasts.
- Backpressure: stream 0x10..0x1F with out_ready toggling 1,0,0,1 repeating → every word appears exactly once in order, occ never exceeds 2, fifo_re never asserted with fifo_empty=1.
- Underrun: prime with 0x2A,0x2B then stop writes, out_ready=1 for 10 cycles → 2 words out, then underrun_cnt=8. With FIFO_READER_HOLD_LAST_EN: out_data=0x2B and out_repeat=1 for those 8 cycles.
- Saturation: CNT_W=4, underrun held 20 cycles → underrun_cnt stops at 0xF.
- Flush mid-flight: assert flush for 1 cycle while inflight=1 and occ=1 → next cycle out_valid=0, state IDLE, the in-flight word is never output, and re-priming then resumes with the following FIFO word.
- Simultaneous capture and pop: occ=1, inflight=1, out_ready=1 for 50 cycles → occ stays 1, output is a gap-free monotone sequence.
